seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 op_code  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 illegal.
REQ-008 result  output  2*WIDTH  registered result of the last completed operation.
REQ-009 busy  output  1  operation in progress; start is ignored while high.
REQ-010 done  output  1  one-cycle pulse marking completion; result and flags are valid from this cycle.
REQ-011 carry  output  1  ADD carry-out, or SUB borrow (a<b); 0 for all other ops.
REQ-012 zero  output  1  result == 0.
REQ-013 div_by_zero  output  1  DIV issued with b=0.
REQ-014 illegal  output  1  op_code 111 issued.

Function
REQ-015 FSM states: IDLE, EXEC, DONE.
- IDLE->EXEC on start=1.
- EXEC->DONE when the op-specific count expires.
- DONE->IDLE after exactly one cycle.
REQ-016 Acceptance edge E0 = rising edge with start=1 and busy=0. At E0, a, b and op_code are latched internally; input changes after E0 have no effect.
REQ-017 Latency: done=1 in the cycle following edge E0+L, where:
- L=1 for ADD, SUB, AND, OR, XOR, illegal, and DIV with b=0;
- L=WIDTH+1 for MUL and for DIV with b!=0.
REQ-018 busy=1 from E0 until the edge that raises done; busy=0 while done=1.
REQ-019 A start held high during the done cycle is accepted (back-to-back issue); a start while busy=1 is dropped, not queued.
REQ-020 ADD: result = zero-extended a+b; carry = bit WIDTH of the sum.
REQ-021 SUB: result = (a-b) in two's complement, sign-extended to 2*WIDTH; carry = 1 when a<b.
REQ-022 MUL: iterative shift-add, one partial product per cycle over WIDTH cycles; result = a*b, exact, no overflow possible.
REQ-023 DIV (b!=0): restoring division, one quotient bit per cycle over WIDTH cycles; result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-024 DIV (b=0): result = {a, all-ones quotient}; div_by_zero=1; no iteration.
REQ-025 AND/OR/XOR: bitwise op zero-extended to 2*WIDTH.
REQ-026 Illegal op: result = 0; illegal=1; zero=1.
REQ-027 Output update timing:
- result, carry, zero, div_by_zero and illegal update only on the edge that raises done.
- They hold until the next completion; intermediate values are never visible on result.
- Flags not applicable to the completed op are 0.

Reset
REQ-028 rst=0 forces IDLE asynchronously and clears result, busy, done, carry, zero, div_by_zero, illegal and all internal counters/accumulators to 0 (zero is 0 during reset).
REQ-029 rst asserted mid-EXEC aborts the operation; no done pulse follows. After release the block is in IDLE and accepts start on the first rising edge with rst=1.
REQ-030 start asserted during reset is ignored.

Verification (WIDTH=4)
REQ-031 ADD a=15 b=1 -> done at L=1, result=8'h10, carry=1, zero=0.
REQ-032 SUB a=3 b=9 -> result=8'hFA, carry=1; SUB a=9 b=4 -> result=8'h05, carry=0.
REQ-033 MUL a=15 b=15 -> busy for 5 cycles, done in the cycle after E0+5, result=8'hE1; start pulsed at E0+2 with ADD is ignored and result stays 8'hE1.
REQ-034 DIV a=13 b=3 -> done after E0+5, result=8'h14; DIV a=5 b=0 -> done after E0+1, result=8'h5F, div_by_zero=1.
REQ-035 MUL a=7 b=7, rst=0 at E0+2 -> all outputs 0 immediately, no done pulse; after release, AND a=12 b=10 -> result=8'h08.
REQ-036 Back-to-back: XOR a=5 b=5 with start held through done -> result=0, zero=1, then the next op is accepted at the done edge; op_code=111 -> result=0, illegal=1.

Source files
------------

// File: rtl/seq_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_alu_if : request/result bundle between a host and the sequential ALU    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface seq_alu_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2:0]             op_code;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;
    logic                   done;
    logic                   carry;
    logic                   zero;
    logic                   div_by_zero;
    logic                   illegal;

    modport master (
        output start, a, b, op_code,
        input  result, busy, done, carry, zero, div_by_zero, illegal
    );

    modport slave (
        input  start, a, b, op_code,
        output result, busy, done, carry, zero, div_by_zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_alu : multi-cycle ALU; single-cycle logic ops, iterative MUL/DIV        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_alu_if.slave    bus
);
    localparam int         c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_AND = 3'b100;
    localparam logic [2:0] c_OP_OR  = 3'b101;
    localparam logic [2:0] c_OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2:0]           r_op;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;

    logic [2*WIDTH-1:0]   r_result;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_dbz;
    logic                 r_illegal;

    logic                 w_accept;
    logic                 w_iter;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_carry;
    logic                 w_dbz;
    logic                 w_illegal;

    // busy is low in DONE, so a start held through the done cycle is taken
    assign w_accept = (r_state != S_EXEC) && bus.start;
    assign w_iter   = (bus.op_code == c_OP_MUL) ||
                      ((bus.op_code == c_OP_DIV) && (bus.b != '0));
    assign w_last   = (r_state == S_EXEC) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_EXEC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.op_code;
            r_cnt    <= w_iter ? c_CNT_W'(WIDTH) : '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_rem    <= '0;
            r_quo    <= bus.a;
        end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_op == c_OP_MUL) begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            if (r_op == c_OP_DIV) begin
                if (w_div_trial[WIDTH]) begin
                    r_rem <= w_div_shift[WIDTH-1:0];
                end else begin
                    r_rem <= w_div_trial[WIDTH-1:0];
                end
                r_quo <= {r_quo[WIDTH-2:0], ~w_div_trial[WIDTH]};
            end
        end
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_dbz     = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                // w_diff[WIDTH] is both the borrow and the sign of the exact difference
                w_res   = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                w_carry = w_diff[WIDTH];
            end
            c_OP_MUL: w_res = r_acc;
            c_OP_DIV: begin
                if (r_b == '0) begin
                    w_res = {r_a, {WIDTH{1'b1}}};
                    w_dbz = 1'b1;
                end else begin
                    w_res = {r_rem, r_quo};
                end
            end
            c_OP_AND: w_res = {{WIDTH{1'b0}}, r_a & r_b};
            c_OP_OR:  w_res = {{WIDTH{1'b0}}, r_a | r_b};
            c_OP_XOR: w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            default:  w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_last) begin
            r_result  <= w_res;
            r_carry   <= w_carry;
            r_zero    <= (w_res == '0);
            r_dbz     <= w_dbz;
            r_illegal <= w_illegal;
        end
    end

    assign bus.result      = r_result;
    assign bus.busy        = (r_state == S_EXEC);
    assign bus.done        = (r_state == S_DONE);
    assign bus.carry       = r_carry;
    assign bus.zero        = r_zero;
    assign bus.div_by_zero = r_dbz;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire
